// File: rtl/io_panel_pkg.sv
// Shared types and constants for the I/O panel: conversion FSM states,
// seven-segment glyphs (active-low {g,f,e,d,c,b,a}) and the display range limit.
package io_panel_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DIV   = 2'd1,
    STORE = 2'd2
  } conv_state_e;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [6:0]  SEG_DASH   = 7'b0111111;
  localparam logic [31:0] OVER_LIMIT = 32'd99;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Non-decimal codes fall back to blank rather than an arbitrary glyph.
  function automatic logic [6:0] seg(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus stability counter: a switch pattern is accepted
// only after it has held for DEBOUNCE_CYCLES consecutive cycles.
module io_debounce #(
  parameter int W               = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] stable_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync1_q, sync2_q, prev_q, stable_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if ((sync2_q != prev_q) || (sync2_q == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sw_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/io_panel.sv
// Board I/O panel: debounced switches into two input ports, and a round-robin
// binary-to-two-digit converter driving six active-low seven-segment displays.
module io_panel
  import io_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_W            = 10
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [SW_W-1:0] sw,
  input  logic [31:0]     out_port0,
  input  logic [31:0]     out_port1,
  input  logic [31:0]     out_port2,
  output logic [31:0]     in_port0,
  output logic [31:0]     in_port1,
  output logic [6:0]      hex0,
  output logic [6:0]      hex1,
  output logic [6:0]      hex2,
  output logic [6:0]      hex3,
  output logic [6:0]      hex4,
  output logic [6:0]      hex5,
  output logic [1:0]      dbg_state_o,
  output logic [1:0]      dbg_k_o
);

  logic [SW_W-1:0] stable;

  io_debounce #(
    .W               (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i    (clock),
    .rst_ni   (resetn),
    .sw_i     (sw),
    .stable_o (stable)
  );

  assign in_port0 = {27'b0, stable[4:0]};
  assign in_port1 = {27'b0, stable[9:5]};

  conv_state_e state_q, state_d;
  logic [1:0]  k_q;
  logic        over_q;
  logic [6:0]  rem_q;
  logic [3:0]  tens_q;
  logic [6:0]  hex_q [6];
  logic [31:0] cur_v;
  logic        load_en, div_step, store_en;
  logic [6:0]  seg_hi, seg_lo;

  always_comb begin
    case (k_q)
      2'd1:    cur_v = out_port1;
      2'd2:    cur_v = out_port2;
      default: cur_v = out_port0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= LOAD;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    state_d = (cur_v > OVER_LIMIT) ? STORE : DIV;
      DIV:     state_d = (rem_q >= 7'd10) ? DIV : STORE;
      STORE:   state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    load_en  = 1'b0;
    div_step = 1'b0;
    store_en = 1'b0;
    case (state_q)
      LOAD:    load_en  = 1'b1;
      DIV:     div_step = (rem_q >= 7'd10);
      STORE:   store_en = 1'b1;
      default: ;
    endcase
  end

  // rem is below ten by the time STORE is reached, so its low nibble is the units digit.
  assign seg_hi = over_q ? SEG_DASH : seg(tens_q);
  assign seg_lo = over_q ? SEG_DASH : seg(rem_q[3:0]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      k_q    <= 2'd0;
      over_q <= 1'b0;
      rem_q  <= '0;
      tens_q <= '0;
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      if (load_en) begin
        over_q <= (cur_v > OVER_LIMIT);
        rem_q  <= cur_v[6:0];
        tens_q <= '0;
      end
      if (div_step) begin
        rem_q  <= rem_q - 7'd10;
        tens_q <= tens_q + 4'd1;
      end
      if (store_en) begin
        case (k_q)
          2'd1: begin
            hex_q[2] <= seg_lo;
            hex_q[3] <= seg_hi;
          end
          2'd2: begin
            hex_q[4] <= seg_lo;
            hex_q[5] <= seg_hi;
          end
          default: begin
            hex_q[0] <= seg_lo;
            hex_q[1] <= seg_hi;
          end
        endcase
        k_q <= (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
      end
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

  assign dbg_state_o = state_q;
  assign dbg_k_o     = k_q;

endmodule

// File: tb/tb_io_panel.sv
// Directed bench for io_panel: reset state, decimal conversion, over-range dash,
// conversion latency, debounce latency and bounce rejection, mid-conversion changes.
module tb_io_panel;

  localparam int DC = 8;
  localparam logic [1:0] S_LOAD = 2'd0, S_DIV = 2'd1, S_STORE = 2'd2;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;
  localparam logic [6:0] SEG_TAB [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic        clock = 1'b0;
  logic        resetn;
  logic [9:0]  sw;
  logic [31:0] out_port0, out_port1, out_port2;
  logic [31:0] in_port0, in_port1;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [1:0]  dbg_state, dbg_k;
  logic [6:0]  hx [6];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  io_panel #(.DEBOUNCE_CYCLES(DC), .SW_W(10)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .sw          (sw),
    .out_port0   (out_port0),
    .out_port1   (out_port1),
    .out_port2   (out_port2),
    .in_port0    (in_port0),
    .in_port1    (in_port1),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .dbg_state_o (dbg_state),
    .dbg_k_o     (dbg_k)
  );

  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for the converter to sit in a given state on a given port.
  task automatic wait_state(input logic [1:0] st, input logic [1:0] kk, input string tag);
    int n = 0;
    while (!(dbg_state == st && dbg_k == kk) && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL %s: timeout waiting for state %0d k %0d, got state %0d k %0d", tag, st, kk, dbg_state, dbg_k);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    sw = '0;
    out_port0 = 32'd42;
    out_port1 = 32'd7;
    out_port2 = 32'd0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (hx[i] !== BLANK) begin
        miscompares++;
        $display("FAIL reset_hex%0d: got %h expected %h", i, hx[i], BLANK);
      end
    end
    vectors++;
    if (in_port0 !== 32'd0 || in_port1 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_in_ports: got %h/%h expected 0/0", in_port0, in_port1);
    end
    vectors++;
    if (dbg_state !== S_LOAD || dbg_k !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_fsm: got state %0d k %0d expected 0 0", dbg_state, dbg_k);
    end
    resetn = 1'b1;
    repeat (36) tick();
    vectors++;
    if (hex1 !== SEG_TAB[4] || hex0 !== SEG_TAB[2]) begin
      miscompares++;
      $display("FAIL first_port0: got %h:%h expected %h:%h", hex1, hex0, SEG_TAB[4], SEG_TAB[2]);
    end
    vectors++;
    if (hex3 !== SEG_TAB[0] || hex2 !== SEG_TAB[7]) begin
      miscompares++;
      $display("FAIL first_port1: got %h:%h expected %h:%h", hex3, hex2, SEG_TAB[0], SEG_TAB[7]);
    end
    vectors++;
    if (hex5 !== SEG_TAB[0] || hex4 !== SEG_TAB[0]) begin
      miscompares++;
      $display("FAIL first_port2: got %h:%h expected %h:%h", hex5, hex4, SEG_TAB[0], SEG_TAB[0]);
    end
  endtask

  task automatic test_over_range();
    out_port1 = 32'd150;
    wait_state(S_STORE, 2'd1, "over150_a");
    tick();
    wait_state(S_STORE, 2'd1, "over150_b");
    tick();
    vectors++;
    if (hex3 !== DASH || hex2 !== DASH) begin
      miscompares++;
      $display("FAIL over150: got %h:%h expected %h:%h", hex3, hex2, DASH, DASH);
    end
    // 100 is the first over-range value: LOAD goes straight to STORE.
    out_port2 = 32'd100;
    wait_state(S_LOAD, 2'd2, "over100_load");
    tick();
    vectors++;
    if (dbg_state !== S_STORE) begin
      miscompares++;
      $display("FAIL over100_latency: got state %0d expected %0d", dbg_state, S_STORE);
    end
    tick();
    vectors++;
    if (hex5 !== DASH || hex4 !== DASH) begin
      miscompares++;
      $display("FAIL over100: got %h:%h expected %h:%h", hex5, hex4, DASH, DASH);
    end
  endtask

  task automatic test_99_latency();
    int n = 0;
    out_port1 = 32'd99;
    wait_state(S_LOAD, 2'd1, "p99_load");
    while (dbg_state != S_STORE && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (n + 1 !== 12) begin
      miscompares++;
      $display("FAIL p99_latency: got %0d cycles expected 12", n + 1);
    end
    tick();
    vectors++;
    if (hex3 !== SEG_TAB[9] || hex2 !== SEG_TAB[9]) begin
      miscompares++;
      $display("FAIL p99_digits: got %h:%h expected %h:%h", hex3, hex2, SEG_TAB[9], SEG_TAB[9]);
    end
    vectors++;
    if (hex1 !== SEG_TAB[4] || hex0 !== SEG_TAB[2]) begin
      miscompares++;
      $display("FAIL p0_undisturbed: got %h:%h expected %h:%h", hex1, hex0, SEG_TAB[4], SEG_TAB[2]);
    end
  endtask

  task automatic test_debounce();
    tick();
    sw = 10'b01101_00011;
    repeat (10) tick();
    vectors++;
    if (in_port0 !== 32'd0 || in_port1 !== 32'd0) begin
      miscompares++;
      $display("FAIL debounce_early: got %0d/%0d expected 0/0", in_port0, in_port1);
    end
    tick();
    vectors++;
    if (in_port0 !== 32'd3 || in_port1 !== 32'd13) begin
      miscompares++;
      $display("FAIL debounce_accept: got %0d/%0d expected 3/13", in_port0, in_port1);
    end
  endtask

  task automatic test_bounce();
    sw = 10'b01101_00010;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) sw = 10'b01101_00011;
      tick();
      vectors++;
      if (in_port0 !== 32'd3 || in_port1 !== 32'd13) begin
        miscompares++;
        $display("FAIL bounce cycle %0d: got %0d/%0d expected 3/13", i, in_port0, in_port1);
      end
    end
  endtask

  task automatic test_change_mid_div();
    out_port0 = 32'd57;
    wait_state(S_LOAD, 2'd0, "mid_load");
    tick();
    vectors++;
    if (dbg_state !== S_DIV) begin
      miscompares++;
      $display("FAIL mid_in_div: got state %0d expected %0d", dbg_state, S_DIV);
    end
    out_port0 = 32'd21;
    wait_state(S_STORE, 2'd0, "mid_store1");
    tick();
    vectors++;
    if (hex1 !== SEG_TAB[5] || hex0 !== SEG_TAB[7]) begin
      miscompares++;
      $display("FAIL mid_old_value: got %h:%h expected %h:%h", hex1, hex0, SEG_TAB[5], SEG_TAB[7]);
    end
    wait_state(S_STORE, 2'd0, "mid_store2");
    tick();
    vectors++;
    if (hex1 !== SEG_TAB[2] || hex0 !== SEG_TAB[1]) begin
      miscompares++;
      $display("FAIL mid_new_value: got %h:%h expected %h:%h", hex1, hex0, SEG_TAB[2], SEG_TAB[1]);
    end
  endtask

  task automatic test_reset_mid_div();
    int n = 0;
    out_port0 = 32'd99;
    wait_state(S_LOAD, 2'd0, "rst_load");
    repeat (3) tick();
    vectors++;
    if (dbg_state !== S_DIV) begin
      miscompares++;
      $display("FAIL rst_in_div: got state %0d expected %0d", dbg_state, S_DIV);
    end
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (hx[i] !== BLANK) begin
        miscompares++;
        $display("FAIL rst_hex%0d: got %h expected %h", i, hx[i], BLANK);
      end
    end
    vectors++;
    if (in_port0 !== 32'd0 || in_port1 !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_in_ports: got %h/%h expected 0/0", in_port0, in_port1);
    end
    vectors++;
    if (dbg_state !== S_LOAD || dbg_k !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_fsm: got state %0d k %0d expected 0 0", dbg_state, dbg_k);
    end
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    vectors++;
    if (hex1 !== BLANK || hex0 !== BLANK || in_port0 !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_still_blank: got %h:%h in0 %0d expected %h:%h in0 0", hex1, hex0, in_port0, BLANK, BLANK);
    end
    while (dbg_state != S_STORE && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (dbg_state !== S_STORE || dbg_k !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_first_store: got state %0d k %0d expected %0d 0", dbg_state, dbg_k, S_STORE);
    end
    tick();
    vectors++;
    if (hex1 !== SEG_TAB[9] || hex0 !== SEG_TAB[9] || hex3 !== BLANK) begin
      miscompares++;
      $display("FAIL rst_restart: got %h:%h hex3 %h expected %h:%h hex3 %h", hex1, hex0, hex3, SEG_TAB[9], SEG_TAB[9], BLANK);
    end
  endtask

  initial begin
    test_reset();
    test_over_range();
    test_99_latency();
    test_debounce();
    test_bounce();
    test_change_mid_div();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
